// File: rtl/rapids_pkg.sv
// rapids_pkg: shared fetch FSM encoding, buffer entry type and instruction constants.
package rapids_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HALT} fetch_state_t;

    typedef struct packed {
        logic [31:0]        addr;
        logic [INSTR_W-1:0] data;
        logic               segv;
    } fetch_entry_t;

    function automatic fetch_entry_t mk_entry(input logic [31:0] addr, input logic [INSTR_W-1:0] data, input logic segv);
        fetch_entry_t e;
        e.addr = addr;
        e.data = data;
        e.segv = segv;
        return e;
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory port plus the controlpath fetch signals.
interface instr_fetch_if;
    import rapids_pkg::*;
    logic               pc_inc;
    logic               flush;
    logic [31:0]        flush_pc;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_fault;
    logic [INSTR_W-1:0] instruction;
    logic               wait_instr;
    logic               instr_segv;
    logic [31:0]        pc_out;

    modport master (
        input  pc_inc, flush, flush_pc, mem_ack, mem_rdata, mem_fault,
        output mem_req, mem_addr, instruction, wait_instr, instr_segv, pc_out
    );

    modport slave (
        output pc_inc, flush, flush_pc, mem_ack, mem_rdata, mem_fault,
        input  mem_req, mem_addr, instruction, wait_instr, instr_segv, pc_out
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch buffer with push/pop/clear; clear wins over push and pop.
module fetch_fifo
    import rapids_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_clear,
    input  fetch_entry_t                   i_entry,
    output fetch_entry_t                   o_head,
    output logic [$clog2(DEPTH + 1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_head, r_tail;
    logic [CW-1:0]  r_count;
    logic           w_push, w_pop;

    assign w_pop   = i_pop && r_count != '0;
    assign w_push  = i_push && (r_count != CW'(DEPTH) || w_pop);
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !i_clear)
            r_mem[r_tail] <= i_entry;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + AW'(1);
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, issues word reads and feeds the controlpath
// from a prefetch buffer; faults and out-of-range PCs become segv markers.
module instr_fetch
    import rapids_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0001_0000
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc, r_addr;
    logic          r_req;
    logic          w_empty, w_pop, w_space, w_illegal, w_issue, w_take, w_push;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_entry, w_head;

    assign w_empty   = w_count == '0;
    assign w_pop     = bus.pc_inc && !w_empty && !bus.flush;
    assign w_space   = w_count != CW'(DEPTH) || w_pop;
    assign w_illegal = r_fetch_pc >= PC_LIMIT || r_fetch_pc[1:0] != 2'b00;
    assign w_issue   = r_state == IDLE && !bus.flush && w_space;
    assign w_take    = r_state == BUSY && bus.mem_ack && !bus.flush;
    assign w_push    = w_take || (w_issue && w_illegal);
    // an illegal PC reserves a slot exactly like a real read, so markers never overflow
    assign w_entry   = w_take ? mk_entry(r_addr, bus.mem_fault ? NOP : bus.mem_rdata, bus.mem_fault)
                              : mk_entry(r_fetch_pc, NOP, 1'b1);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.flush),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.mem_req     = r_req;
    assign bus.mem_addr    = r_addr;
    assign bus.instruction = w_empty ? NOP : w_head.data;
    assign bus.wait_instr  = w_empty;
    assign bus.instr_segv  = !w_empty && w_head.segv;
    assign bus.pc_out      = w_empty ? r_fetch_pc : w_head.addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.flush)
                        r_fetch_pc <= bus.flush_pc;
                    else if (w_space && w_illegal)
                        r_state <= HALT;
                    else if (w_space) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        r_fetch_pc <= bus.flush_pc;
                        r_req      <= !bus.mem_ack;
                        r_state    <= bus.mem_ack ? IDLE : DRAIN;
                    end else if (bus.mem_ack) begin
                        r_req      <= 1'b0;
                        r_state    <= bus.mem_fault ? HALT : IDLE;
                        r_fetch_pc <= bus.mem_fault ? r_fetch_pc : r_fetch_pc + 32'd4;
                    end
                end
                // the bus cannot cancel a read, so wait for its ack and drop the data
                DRAIN: begin
                    if (bus.flush)
                        r_fetch_pc <= bus.flush_pc;
                    if (bus.mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                HALT: begin
                    if (bus.flush) begin
                        r_fetch_pc <= bus.flush_pc;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios against a small memory model with hand-computed expectations.
module tb_instr_fetch;
    import rapids_pkg::*;
    localparam logic [31:0] LIMIT = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if bus();
    instr_fetch #(.DEPTH(2), .RESET_PC(32'h0), .PC_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int total = 0;
    int bad = 0;
    bit auto_mem = 1'b1;
    logic [31:0] fault_addr = 32'hFFFF_FFFF;
    logic a_ack = 1'b0, a_fault = 1'b0, man_ack = 1'b0, man_fault = 1'b0;
    logic [31:0] a_data = '0, man_data = '0;
    fetch_entry_t dq[$];
    logic [31:0] req_q[$];
    logic prev_req = 1'b0;
    int bad_seen = 0;

    assign bus.mem_ack   = auto_mem ? a_ack : man_ack;
    assign bus.mem_rdata = auto_mem ? a_data : man_data;
    assign bus.mem_fault = auto_mem ? a_fault : man_fault;

    // zero-wait memory: acks in the first cycle a request is seen
    always @(negedge clk) begin
        a_ack   = bus.mem_req;
        a_data  = 32'hA000_0000 + bus.mem_addr;
        a_fault = bus.mem_req && bus.mem_addr == fault_addr;
    end

    always @(posedge clk) begin
        if (!rst && bus.pc_inc && !bus.flush && !bus.wait_instr)
            dq.push_back(mk_entry(bus.pc_out, bus.instruction, bus.instr_segv));
        if (bus.instruction == 32'hDEAD || bus.instruction == 32'hBAD0_0000)
            bad_seen++;
        if (bus.mem_req && !prev_req)
            req_q.push_back(bus.mem_addr);
        prev_req = bus.mem_req;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk);
            #2;
            ok = bus.mem_req;
        end
    endtask

    task automatic ack_once(input logic [31:0] data, input logic fault);
        @(negedge clk);
        man_ack = 1'b1; man_data = data; man_fault = fault;
        @(negedge clk);
        man_ack = 1'b0; man_fault = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk);
        bus.pc_inc = 1'b1;
        @(negedge clk);
        bus.pc_inc = 1'b0;
    endtask

    task automatic test_reset();
        int rb;
        rb = req_q.size();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got %h want 0", bus.mem_addr); end
        total++; if (bus.instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got %h want 0", bus.instruction); end
        total++; if (bus.wait_instr !== 1'b1) begin bad++; $display("FAIL rst_wait got %b want 1", bus.wait_instr); end
        total++; if (bus.instr_segv !== 1'b0) begin bad++; $display("FAIL rst_segv got %b want 0", bus.instr_segv); end
        total++; if (bus.pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got %h want 0", bus.pc_out); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (req_q.size() - rb !== 2) begin bad++; $display("FAIL fill_reqs got %0d want 2", req_q.size() - rb); end
        else if (req_q[rb] !== 32'h0 || req_q[rb+1] !== 32'h4) begin bad++; $display("FAIL fill_addrs got %h,%h want 0,4", req_q[rb], req_q[rb+1]); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_stall got %b want 0", bus.mem_req); end
        total++; if (bus.instruction !== 32'hA000_0000) begin bad++; $display("FAIL fill_instr got %h want a0000000", bus.instruction); end
        total++; if (bus.pc_out !== 32'h0 || bus.wait_instr !== 1'b0) begin bad++; $display("FAIL fill_head got pc=%h wait=%b want pc=0 wait=0", bus.pc_out, bus.wait_instr); end
    endtask

    task automatic test_stream();
        int rb, db, nd, nr;
        auto_mem = 1'b1;
        do_reset();
        rb = req_q.size();
        db = dq.size();
        repeat (12) @(negedge clk);
        bus.pc_inc = 1'b1;
        repeat (30) @(negedge clk);
        bus.pc_inc = 1'b0;
        repeat (4) @(negedge clk);
        nd = dq.size() - db;
        nr = req_q.size() - rb;
        total++; if (nd < 4) begin bad++; $display("FAIL stream_count got %0d want >=4", nd); end
        for (int i = 0; i < nd; i++) begin
            total++;
            if (dq[db+i].addr !== 32'(4 * i) || dq[db+i].data !== 32'hA000_0000 + 32'(4 * i) || dq[db+i].segv !== 1'b0) begin
                bad++; $display("FAIL stream_entry[%0d] got %h/%h want %h/%h", i, dq[db+i].addr, dq[db+i].data, 32'(4 * i), 32'hA000_0000 + 32'(4 * i));
            end
        end
        total++; if (nr < nd || nr > nd + 2) begin bad++; $display("FAIL stream_reqs got %0d want %0d..%0d", nr, nd, nd + 2); end
        for (int i = 0; i < nr; i++) begin
            total++; if (req_q[rb+i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_req[%0d] got %h want %h", i, req_q[rb+i], 32'(4 * i)); end
        end
    endtask

    task automatic test_fault();
        int rb, db;
        bit ok;
        auto_mem = 1'b1;
        fault_addr = 32'h8;
        do_reset();
        rb = req_q.size();
        db = dq.size();
        repeat (12) @(negedge clk);
        pop1();
        repeat (6) @(negedge clk);
        pop1();
        total++; if (bus.instr_segv !== 1'b1 || bus.wait_instr !== 1'b0) begin bad++; $display("FAIL fault_segv got segv=%b wait=%b want 1/0", bus.instr_segv, bus.wait_instr); end
        total++; if (bus.instruction !== 32'h0) begin bad++; $display("FAIL fault_instr got %h want 0", bus.instruction); end
        total++; if (bus.pc_out !== 32'h8) begin bad++; $display("FAIL fault_pc got %h want 8", bus.pc_out); end
        total++; if (dq.size() - db !== 2) begin bad++; $display("FAIL fault_deliv got %0d want 2", dq.size() - db); end
        else if (dq[db].addr !== 32'h0 || dq[db+1].addr !== 32'h4 || dq[db+1].data !== 32'hA000_0004) begin bad++; $display("FAIL fault_order got %h,%h want 0,4", dq[db].addr, dq[db+1].addr); end
        repeat (8) @(negedge clk);
        total++; if (bus.mem_req !== 1'b0 || req_q.size() - rb !== 3) begin bad++; $display("FAIL fault_halt got req=%b n=%0d want 0/3", bus.mem_req, req_q.size() - rb); end
        fault_addr = 32'hFFFF_FFFF;
        bus.flush = 1'b1; bus.flush_pc = 32'h40;
        @(negedge clk);
        bus.flush = 1'b0;
        total++; if (bus.wait_instr !== 1'b1) begin bad++; $display("FAIL fault_flush_wait got %b want 1", bus.wait_instr); end
        wait_req(ok);
        total++; if (!ok || bus.mem_addr !== 32'h40) begin bad++; $display("FAIL fault_refetch got ok=%b addr=%h want 40", ok, bus.mem_addr); end
    endtask

    task automatic test_flush_busy();
        bit ok;
        int bs;
        auto_mem = 1'b0;
        do_reset();
        bs = bad_seen;
        wait_req(ok);
        ack_once(32'hA000_0000, 1'b0);
        wait_req(ok);
        total++; if (!ok || bus.mem_addr !== 32'h4) begin bad++; $display("FAIL fb_busy4 got ok=%b addr=%h want 4", ok, bus.mem_addr); end
        @(negedge clk);
        bus.flush = 1'b1; bus.flush_pc = 32'h100;
        @(negedge clk);
        bus.flush = 1'b0;
        total++; if (bus.wait_instr !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin bad++; $display("FAIL fb_drain got wait=%b req=%b addr=%h want 1/1/4", bus.wait_instr, bus.mem_req, bus.mem_addr); end
        repeat (2) @(negedge clk);
        ack_once(32'hDEAD, 1'b0);
        total++; if (bus.wait_instr !== 1'b1) begin bad++; $display("FAIL fb_discard got wait=%b want 1", bus.wait_instr); end
        wait_req(ok);
        total++; if (!ok || bus.mem_addr !== 32'h100 || bus.wait_instr !== 1'b1) begin bad++; $display("FAIL fb_redirect got ok=%b addr=%h wait=%b want 100/1", ok, bus.mem_addr, bus.wait_instr); end
        ack_once(32'h1234, 1'b0);
        total++; if (bus.instruction !== 32'h1234 || bus.pc_out !== 32'h100) begin bad++; $display("FAIL fb_new got %h@%h want 1234@100", bus.instruction, bus.pc_out); end
        total++; if (bad_seen !== bs) begin bad++; $display("FAIL fb_dead_shown got %0d want %0d", bad_seen, bs); end
    endtask

    task automatic test_limit();
        int rb;
        auto_mem = 1'b1;
        bus.flush = 1'b1; bus.flush_pc = LIMIT - 32'd4;
        do_reset();
        rb = req_q.size();
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (bus.instruction !== 32'hA000_FFFC || bus.pc_out !== 32'hFFFC || bus.instr_segv !== 1'b0) begin bad++; $display("FAIL lim_word got %h@%h segv=%b want a000fffc@fffc", bus.instruction, bus.pc_out, bus.instr_segv); end
        pop1();
        total++; if (bus.instr_segv !== 1'b1 || bus.pc_out !== LIMIT || bus.instruction !== 32'h0) begin bad++; $display("FAIL lim_marker got segv=%b pc=%h instr=%h want 1/%h/0", bus.instr_segv, bus.pc_out, bus.instruction, LIMIT); end
        total++; if (req_q.size() - rb !== 1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL lim_reqs got n=%0d req=%b want 1/0", req_q.size() - rb, bus.mem_req); end
        else if (req_q[rb] !== 32'hFFFC) begin bad++; $display("FAIL lim_addr got %h want fffc", req_q[rb]); end
    endtask

    task automatic test_reset_busy();
        bit ok;
        int bs;
        auto_mem = 1'b0;
        do_reset();
        bs = bad_seen;
        wait_req(ok);
        ack_once(32'hA000_0000, 1'b0);
        wait_req(ok);
        total++; if (!ok || bus.mem_addr !== 32'h4) begin bad++; $display("FAIL rb_busy4 got ok=%b addr=%h want 4", ok, bus.mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.pc_out !== 32'h0) begin bad++; $display("FAIL rb_rst got req=%b addr=%h pc=%h want 0/0/0", bus.mem_req, bus.mem_addr, bus.pc_out); end
        total++; if (bus.instruction !== 32'h0 || bus.wait_instr !== 1'b1 || bus.instr_segv !== 1'b0) begin bad++; $display("FAIL rb_rst_head got instr=%h wait=%b segv=%b want 0/1/0", bus.instruction, bus.wait_instr, bus.instr_segv); end
        rst = 1'b0;
        man_ack = 1'b1; man_data = 32'hBAD0_0000;
        @(negedge clk);
        man_ack = 1'b0;
        total++; if (bus.wait_instr !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rb_stale got wait=%b req=%b addr=%h want 1/1/0", bus.wait_instr, bus.mem_req, bus.mem_addr); end
        ack_once(32'h55, 1'b0);
        total++; if (bus.instruction !== 32'h55 || bus.pc_out !== 32'h0) begin bad++; $display("FAIL rb_first got %h@%h want 55@0", bus.instruction, bus.pc_out); end
        total++; if (bad_seen !== bs) begin bad++; $display("FAIL rb_stale_shown got %0d want %0d", bad_seen, bs); end
    endtask

    initial begin
        bus.pc_inc = 1'b0;
        bus.flush = 1'b0;
        bus.flush_pc = 32'h0;
        test_reset();
        test_stream();
        test_fault();
        test_flush_busy();
        test_limit();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
